// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM encoding and default sizes for the MAC operand/datapath blocks
package mac_pkg;
  localparam int MAC_DATA_W = 8;
  localparam int MAC_DEPTH  = 8;
  localparam int MAC_ADDR_W = 3;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;
endpackage

// File: rtl/mac_operand_regfile.sv
// mac_operand_regfile: DEPTH-entry register array, synchronous write, combinational read, async clear
module mac_operand_regfile #(
  parameter int W      = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];
  // clear every entry on reset, otherwise commit the write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/mac_operand_buffer.sv
// mac_operand_buffer: holds operand pairs and sequences them to the MAC controller; err is a registered pulse one cycle after the offending event
module mac_operand_buffer #(
  parameter int DATA_W = mac_pkg::MAC_DATA_W,
  parameter int DEPTH  = mac_pkg::MAC_DEPTH,
  parameter int ADDR_W = mac_pkg::MAC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  input  logic              count_enable,
  input  logic              load_out,
  output logic              go,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic              cmp,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import mac_pkg::*;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     consumed, len_q;
  logic [2*DATA_W-1:0] rdata;
  logic                len_ok, accept, step, overrun;
  assign len_ok  = (len != '0) && (len <= LEN_MAX);
  assign accept  = (state_q == IDLE) && start && len_ok;
  assign step    = (state_q == RUN) && count_enable && (consumed != len_q);
  assign overrun = (state_q == RUN) && count_enable && (consumed == len_q);
  mac_operand_regfile #(.W(2*DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en && (state_q == IDLE)),
    .waddr (wr_addr),
    .wdata ({wr_a, wr_b}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
  assign a_data = rdata[2*DATA_W-1:DATA_W];
  assign b_data = rdata[DATA_W-1:0];
  assign go     = (state_q == ARM);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next-state: ARM and DONE are single-cycle, RUN exits only on load_out once cmp is up
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? ARM : IDLE;
      ARM:     state_d = RUN;
      RUN:     state_d = (load_out && cmp) ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end
  // job bookkeeping: pointer saturates at len_q-1, cmp latches when the last pair is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      consumed <= '0;
      len_q    <= '0;
      cmp      <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= ((state_q == IDLE) && start && !len_ok) || overrun;
      if (accept) begin
        len_q    <= len;
        rd_ptr   <= '0;
        consumed <= '0;
      end
      if (step) begin
        consumed <= consumed + 1'b1;
        cmp      <= cmp | ((consumed + 1'b1) == len_q);
        if (({1'b0, rd_ptr} + 1'b1) < len_q) rd_ptr <= rd_ptr + 1'b1;
      end
      if ((state_q == RUN) && load_out && cmp) cmp <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_operand_buffer.sv
// tb_mac_operand_buffer: randomized scenario bench against an array model of the operand buffer
module tb_mac_operand_buffer;
  logic       clk = 0, rst_n = 0;
  logic       wr_en = 0, start = 0, count_enable = 0, load_out = 0;
  logic [2:0] wr_addr = 0;
  logic [7:0] wr_a = 0, wr_b = 0;
  logic [3:0] len = 0;
  logic       go, cmp, busy, done, err;
  logic [7:0] a_data, b_data;
  logic [7:0] ma [8];
  logic [7:0] mb [8];
  int tests = 0, fails = 0;

  mac_operand_buffer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .len(len), .start(start), .count_enable(count_enable), .load_out(load_out),
    .go(go), .a_data(a_data), .b_data(b_data), .cmp(cmp), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 8; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
  endtask

  task automatic write_pair(input int addr, input logic [7:0] a, input logic [7:0] b);
    wr_en = 1; wr_addr = addr[2:0]; wr_a = a; wr_b = b;
    cyc;
    wr_en = 0;
    ma[addr] = a;
    mb[addr] = b;
  endtask

  task automatic fill_random;
    for (int i = 0; i < 8; i++) write_pair(i, 8'($urandom), 8'($urandom));
  endtask

  task automatic run_job(input int n, input bit combo);
    int addr;
    len = n[3:0]; start = 1;
    if (combo) begin
      addr = $urandom_range(0, 7);
      wr_en = 1; wr_addr = addr[2:0]; wr_a = 8'($urandom); wr_b = 8'($urandom);
      ma[addr] = wr_a;
      mb[addr] = wr_b;
    end
    cyc;
    start = 0; wr_en = 0;
    tests++; if (go !== 1'b1) begin fails++; $display("FAIL job_go got %b exp 1 len %0d", go, n); end
    tests++; if (busy !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL job_arm busy %b err %b exp 1 0", busy, err); end
    cyc;
    tests++; if (go !== 1'b0) begin fails++; $display("FAIL job_go_pulse got %b exp 0", go); end
    load_out = 1;
    cyc;
    load_out = 0;
    tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL early_load done %b busy %b exp 0 1", done, busy); end
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) cyc;
      count_enable = 1;
      tests++; if (a_data !== ma[k] || b_data !== mb[k]) begin fails++; $display("FAIL pair_%0d got %h/%h exp %h/%h", k, a_data, b_data, ma[k], mb[k]); end
      cyc;
      count_enable = 0;
      tests++; if (cmp !== (k == n - 1)) begin fails++; $display("FAIL cmp_after_%0d got %b exp %b", k, cmp, k == n - 1); end
    end
    load_out = 1;
    cyc;
    load_out = 0;
    tests++; if (done !== 1'b1 || cmp !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL retire done %b cmp %b busy %b exp 1 0 1", done, cmp, busy); end
    cyc;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_after done %b busy %b exp 0 0", done, busy); end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) cyc;
    rst_n = 1;
    #1;
    clear_model;
    tests++; if ({go, cmp, busy, done, err} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 00000", {go, cmp, busy, done, err}); end
    tests++; if (a_data !== 8'h00 || b_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h/%h exp 00/00", a_data, b_data); end
    cyc;
  endtask

  task automatic test_normal;
    write_pair(0, 8'd2, 8'd5);
    write_pair(1, 8'd3, 8'd6);
    write_pair(2, 8'd4, 8'd7);
    run_job(3, 0);
  endtask

  task automatic test_illegal_len;
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? 4'd0 : 4'd9; start = 1;
      cyc;
      start = 0;
      tests++; if (err !== 1'b1 || go !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL illegal_len_%0d err %b go %b busy %b exp 1 0 0", len, err, go, busy); end
      cyc;
      tests++; if (err !== 1'b0 || go !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL illegal_after_%0d err %b go %b busy %b exp 0 0 0", len, err, go, busy); end
    end
  endtask

  task automatic test_overrun;
    fill_random;
    len = 2; start = 1;
    cyc;
    start = 0;
    cyc;
    for (int k = 0; k < 3; k++) begin
      count_enable = 1;
      tests++; if (a_data !== ma[k > 1 ? 1 : k]) begin fails++; $display("FAIL ovr_a_%0d got %h exp %h", k, a_data, ma[k > 1 ? 1 : k]); end
      cyc;
      count_enable = 0;
      tests++; if (err !== (k == 2) || cmp !== (k >= 1)) begin fails++; $display("FAIL ovr_flags_%0d err %b cmp %b exp %b %b", k, err, cmp, k == 2, k >= 1); end
    end
    tests++; if (a_data !== ma[1] || b_data !== mb[1]) begin fails++; $display("FAIL ovr_hold got %h/%h exp %h/%h", a_data, b_data, ma[1], mb[1]); end
    cyc;
    tests++; if (err !== 1'b0 || cmp !== 1'b1) begin fails++; $display("FAIL ovr_settle err %b cmp %b exp 0 1", err, cmp); end
    load_out = 1;
    cyc;
    load_out = 0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL ovr_done got %b exp 1", done); end
    cyc;
  endtask

  task automatic test_lockout;
    len = 2; start = 1;
    cyc;
    start = 0;
    cyc;
    wr_en = 1; wr_addr = 0; wr_a = 8'hFF; wr_b = 8'hFF; start = 1; len = 3;
    cyc;
    wr_en = 0; start = 0;
    tests++; if (err !== 1'b0 || go !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL busy_start err %b go %b busy %b exp 0 0 1", err, go, busy); end
    tests++; if (a_data !== ma[0]) begin fails++; $display("FAIL lockout_live got %h exp %h", a_data, ma[0]); end
    repeat (2) begin count_enable = 1; cyc; end
    count_enable = 0;
    tests++; if (cmp !== 1'b1) begin fails++; $display("FAIL lockout_len got cmp %b exp 1", cmp); end
    load_out = 1;
    cyc;
    load_out = 0;
    cyc;
    run_job(2, 0);
  endtask

  task automatic test_reset_mid_job;
    fill_random;
    len = 3; start = 1;
    cyc;
    start = 0;
    cyc;
    count_enable = 1;
    cyc;
    count_enable = 0;
    rst_n = 0;
    #1;
    clear_model;
    tests++; if ({go, cmp, busy, done, err} !== 5'b0) begin fails++; $display("FAIL midrst_ctrl got %b exp 00000", {go, cmp, busy, done, err}); end
    tests++; if (a_data !== 8'h00 || b_data !== 8'h00) begin fails++; $display("FAIL midrst_data got %h/%h exp 00/00", a_data, b_data); end
    cyc;
    rst_n = 1;
    cyc;
    fill_random;
    run_job($urandom_range(1, 8), 0);
  endtask

  task automatic test_random_jobs;
    for (int j = 0; j < 8; j++) begin
      repeat ($urandom_range(0, 4)) write_pair($urandom_range(0, 7), 8'($urandom), 8'($urandom));
      run_job((j == 0) ? 8 : ((j == 1) ? 1 : $urandom_range(1, 8)), j[0]);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_illegal_len;
    test_overrun;
    test_lockout;
    test_reset_mid_job;
    test_random_jobs;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_operand_buffer.md
Name: mac_operand_buffer

Overview:
- Upstream operand stage for the MAC control/datapath pair.
- Host writes paired operand vectors (A[i], B[i]) into a small register-array buffer, then issues start.
- The block pulses go to the MAC controller and presents one operand pair per count_enable.
- It drives cmp when the last pair has been consumed, and retires the job when the controller asserts load_out.

Parameters:
- DATA_W, 8, operand width of A and B.
- DEPTH, 8, number of operand pairs held (power of two).
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for the operand buffer.
- wr_addr  in  ADDR_W  write index.
- wr_a  in  DATA_W  A operand written at wr_addr.
- wr_b  in  DATA_W  B operand written at wr_addr.
- len  in  ADDR_W+1  job length in pairs; legal range 1..DEPTH.
- start  in  1  job request; sampled in IDLE only.
- count_enable  in  1  from MAC controller; current pair is being loaded.
- load_out  in  1  from MAC controller; accumulated result is being captured.
- go  out  1  one-cycle job start pulse to MAC controller.
- a_data  out  DATA_W  A operand at the read pointer.
- b_data  out  DATA_W  B operand at the read pointer.
- cmp  out  1  all len pairs consumed.
- busy  out  1  job in progress (state is not IDLE).
- done  out  1  one-cycle pulse on job retirement.
- err  out  1  one-cycle pulse on illegal len or count_enable overrun.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; rd_ptr=0; consumed=0; len_q=0; all buffer entries=0.
  - go, cmp, busy, done, err = 0; a_data and b_data = 0.
- Buffer:
  - Register array of DEPTH x {A,B}.
  - A write commits on the clock edge when wr_en=1 and state=IDLE.
  - wr_en is ignored (no write) in any other state.
- Read path: a_data and b_data are combinational reads of buf[rd_ptr], valid in the same cycle count_enable is high.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - start=1 with 1<=len<=DEPTH: latch len_q, clear rd_ptr and consumed, go to ARM.
  - start=1 with len=0 or len>DEPTH: err=1 for one cycle, stay in IDLE.
  - wr_en and start in the same cycle: the write commits first, so the data is visible in RUN.
- ARM:
  - go=1 for exactly this cycle; busy=1.
  - Next state is RUN unconditionally.
- RUN:
  - On count_enable with consumed<len_q: consumed+=1 and rd_ptr+=1.
  - rd_ptr saturates at len_q-1; it never wraps and never passes len_q-1.
  - cmp is registered: cmp=1 from the cycle after consumed reaches len_q and is held until exit.
  - On count_enable with consumed==len_q (overrun): err=1 for one cycle; no pointer change.
  - load_out=1 while cmp=1: move to DONE.
  - load_out while cmp=0 is ignored.
- DONE:
  - done=1 for one cycle; cmp drops; busy=0 from the next cycle.
  - Next state is IDLE. Buffer contents are retained for re-run.
- Other rules:
  - start while busy is ignored and produces no err.
  - Latency: start to go is 1 cycle; load_out to done is 1 cycle.
  - A job of N pairs needs N count_enable pulses.
  - Reset mid-job: immediate return to IDLE with all outputs at reset values and the buffer cleared; the MAC controller is reset by the same rst_n.

Decomposition:
- Shared package mac_pkg:
  - FSM state encoding (IDLE=2'b00, ARM=2'b01, RUN=2'b10, DONE=2'b11).
  - DATA_W, DEPTH and ADDR_W defaults, shared with the MAC datapath.
- One natural sub-module, mac_operand_regfile:
  - DEPTH x 2*DATA_W register array, synchronous write, combinational read, async clear.
  - The FSM, pointer and counters stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Response: go=cmp=busy=done=err=0 and a_data=b_data=0 on the release cycle.
- Normal job, len=3:
  - Stimulus: write A={2,3,4}, B={5,6,7} at addresses 0..2, then start.
  - Response: go pulses 1 cycle after start.
  - Response: a_data/b_data read 2/5, 3/6, 4/7 on the 3 count_enable cycles.
  - Response: cmp=1 the cycle after the 3rd count_enable; load_out gives done the next cycle, then busy=0.
- Illegal length:
  - Stimulus: start with len=0, then start with len=9 (DEPTH=8).
  - Response: err pulses once for each; go never asserts; state stays IDLE.
- Overrun and saturation:
  - Stimulus: len=2, then 3 count_enable pulses.
  - Response: err on the 3rd; rd_ptr stays 1; a_data holds A[1]; cmp stays 1.
- Write lockout and start while busy:
  - Stimulus: during RUN, wr_en to addr 0 with A=0xFF, plus a second start.
  - Response: buf[0] is unchanged on re-run; the second start has no effect and no err.
- Reset mid-job:
  - Stimulus: rst_n=0 while in RUN with consumed=1.
  - Response: outputs go to reset values asynchronously; buffer reads 0; a new job runs correctly after re-fill.
